draw_cmd_dispatcher: RTL

Command front-end that sits directly upstream of the rasterizer top level. It walks a list of draw descriptors in main memory and loads each one into the rasterizer's instruction inputs. It issues a one-cycle rasterizer start and waits for the rasterizer done before fetching the next descriptor. It owns the main-memory read port only while no draw is in flight; the system muxes that port by `mem_rd_owner`.

---
 rtl/draw_cmd_dispatcher.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/draw_cmd_dispatcher.sv
// Walks a list of 8-word draw descriptors in main memory and launches each one on the rasterizer.
// Optional macro DISPATCH_PERF_EN adds the last_draw_cycles / total_busy_cycles counters.
module draw_cmd_dispatcher #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_RD_LATENCY = 1,
  parameter int MAX_CMDS_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     cmd_list_ptr,
  input  logic [MAX_CMDS_WIDTH-1:0] num_cmds,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [MAX_CMDS_WIDTH-1:0] cmds_issued,
  output logic [MAX_CMDS_WIDTH-1:0] cmds_skipped,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
  output logic                      mem_rd_en,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic                      mem_rd_owner,
  output logic [DATA_WIDTH-1:0]     rast_i_array_ptr,
  output logic [DATA_WIDTH-1:0]     rast_v_array_ptr,
  output logic [DATA_WIDTH-1:0]     rast_f_array_ptr,
  output logic [31:0]               rast_ctrl_reg0,
  output logic [31:0]               rast_ctrl_reg1,
  output logic [31:0]               rast_res_reg,
  output logic                      rast_start,
  input  logic                      rast_done,
  input  logic                      rast_ready
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]               last_draw_cycles,
  output logic [31:0]               total_busy_cycles
`endif
);

  localparam int LAT = MEM_RD_LATENCY;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_WAIT_RDY, S_LAUNCH, S_RUN, S_FINISH
  } state_t;

  state_t                    state_reg, state_next;
  logic [ADDR_WIDTH-1:0]     base_reg;
  logic [MAX_CMDS_WIDTH-1:0] num_reg, idx_reg, idx_inc;
  logic [2:0]                rd_cnt_reg;
  logic                      abort_reg, abort_eff;
  logic [LAT-1:0]            pipe_vld_reg;
  logic [2:0]                pipe_idx_reg [LAT];
  logic [DATA_WIDTH-1:0]     word_reg [6];
  logic                      cap_vld, skip, advance, adv_last;
  logic [2:0]                cap_idx;

  assign idx_inc   = idx_reg + MAX_CMDS_WIDTH'(1);
  assign cap_vld   = pipe_vld_reg[LAT-1];
  assign cap_idx   = pipe_idx_reg[LAT-1];
  assign abort_eff = abort_reg | abort;
  assign skip      = (word_reg[4][15:0] == 16'h0);
  assign adv_last  = (idx_inc == num_reg) | abort_eff;
  // An aborted descriptor is retired at CHECK exactly like a skip, just without counting it.
  assign advance   = (state_reg == S_CHECK && (skip || abort_eff)) ||
                     (state_reg == S_RUN && rast_done);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (start) state_next = (num_cmds == '0) ? S_FINISH : S_FETCH;
      S_FETCH:    if (cap_vld && cap_idx == 3'd5) state_next = S_CHECK;
      S_CHECK:    state_next = advance ? (adv_last ? S_FINISH : S_FETCH) : S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (abort_eff)       state_next = S_FINISH;
        else if (rast_ready) state_next = S_LAUNCH;
      end
      S_LAUNCH:   state_next = S_RUN;
      S_RUN:      if (rast_done) state_next = adv_last ? S_FINISH : S_FETCH;
      S_FINISH:   state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    mem_rd_owner = 1'b0;
    mem_rd_en    = 1'b0;
    rast_start   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        busy         = 1'b1;
        mem_rd_owner = 1'b1;
        mem_rd_en    = (rd_cnt_reg < 3'd6);
      end
      S_CHECK, S_WAIT_RDY, S_RUN: busy = 1'b1;
      S_LAUNCH: begin
        busy       = 1'b1;
        rast_start = 1'b1;
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign mem_rd_addr = mem_rd_en ? base_reg + ADDR_WIDTH'(rd_cnt_reg) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base_reg     <= '0;
      num_reg      <= '0;
      idx_reg      <= '0;
      cmds_issued  <= '0;
      cmds_skipped <= '0;
      abort_reg    <= 1'b0;
      rd_cnt_reg   <= 3'd0;
    end else begin
      if (state_reg == S_IDLE) begin
        abort_reg <= 1'b0;
        if (start) begin
          base_reg     <= cmd_list_ptr;
          num_reg      <= num_cmds;
          idx_reg      <= '0;
          cmds_issued  <= '0;
          cmds_skipped <= '0;
        end
      end else if (abort) begin
        abort_reg <= 1'b1;
      end
      if (advance) begin
        idx_reg  <= idx_inc;
        base_reg <= base_reg + ADDR_WIDTH'(8);
      end
      if (state_reg == S_CHECK && skip) cmds_skipped <= cmds_skipped + MAX_CMDS_WIDTH'(1);
      if (state_reg == S_LAUNCH)        cmds_issued  <= cmds_issued + MAX_CMDS_WIDTH'(1);
      if (state_reg != S_FETCH)         rd_cnt_reg   <= 3'd0;
      else if (mem_rd_en)               rd_cnt_reg   <= rd_cnt_reg + 3'd1;
    end
  end

  // Read-return steering: each word's index travels alongside its valid bit for LAT cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_vld_reg <= '0;
      for (int i = 0; i < LAT; i++) pipe_idx_reg[i] <= 3'd0;
    end else begin
      pipe_vld_reg[0] <= mem_rd_en;
      pipe_idx_reg[0] <= rd_cnt_reg;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld_reg[i] <= pipe_vld_reg[i-1];
        pipe_idx_reg[i] <= pipe_idx_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 6; i++) word_reg[i] <= '0;
    end else if (state_reg == S_FETCH && cap_vld) begin
      for (int i = 0; i < 6; i++)
        if (cap_idx == 3'(i)) word_reg[i] <= mem_rd_data;
    end
  end

  assign rast_i_array_ptr = word_reg[0];
  assign rast_v_array_ptr = word_reg[1];
  assign rast_f_array_ptr = word_reg[2];
  assign rast_ctrl_reg0   = 32'(word_reg[3]);
  assign rast_ctrl_reg1   = 32'(word_reg[4]);
  assign rast_res_reg     = 32'(word_reg[5]);

`ifdef DISPATCH_PERF_EN
  logic [31:0] draw_cnt_reg;

  // draw_cnt_reg counts the LAUNCH cycle plus RUN cycles seen so far; the done cycle adds one more.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      draw_cnt_reg      <= '0;
      last_draw_cycles  <= '0;
      total_busy_cycles <= '0;
    end else begin
      if (state_reg == S_IDLE && start) begin
        last_draw_cycles  <= '0;
        total_busy_cycles <= '0;
      end else if (busy && total_busy_cycles != '1) begin
        total_busy_cycles <= total_busy_cycles + 32'd1;
      end
      if (state_reg == S_LAUNCH) begin
        draw_cnt_reg <= 32'd1;
      end else if (state_reg == S_RUN) begin
        draw_cnt_reg <= draw_cnt_reg + 32'd1;
        if (rast_done) last_draw_cycles <= draw_cnt_reg + 32'd1;
      end
    end
  end
`endif

endmodule
